module_mem_arbiter: RTL and testbench

- Two-master, single-port arbiter that shares the unified instruction/data memory of the multicycle processor.
- Master 0 is the processor's memory interface; master 1 is the program loader/peripheral master.
- Sequences one memory transaction at a time, honours the memory's fixed read latency and returns a one-cycle acknowledge to the winning master.
- Sits between the processor datapath's address/write-data path and the memory block.

---
 rtl/module_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_module_mem_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/module_mem_arbiter.sv
// Two-master, single-port memory arbiter for the multicycle processor.
// Master 0 is the processor memory interface and master 1 is the loader or
// peripheral master. One transaction is in flight at a time, the fixed
// memory read latency is honoured, and the winning master gets a one-cycle
// acknowledge.
//
// Handshake: a master raises req with stable we/addr/wdata and holds req
// until it sees ack=1 for one cycle. Its rdata is valid during that ack
// cycle. The request is latched on grant, so later input changes (including
// an early req drop) do not affect the transaction in flight.
module module_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    output logic              m0_ack_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic              m1_ack_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o,
    output logic              owner_o,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    // The WAIT counter reaches zero in the cycle the read data is valid.
    localparam logic [2:0] LAT_LOAD = 3'(MEM_LATENCY - 1);

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q, last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                grant;

    // State and datapath registers; last_served resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cnt_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    // Next-state logic: arbitration, request latching, latency count and read capture.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        grant    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    // On a tie the master that was not served last wins.
                    grant   = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
                    owner_d = grant;
                    last_d  = grant;
                    we_d    = grant ? m1_we_i    : m0_we_i;
                    addr_d  = grant ? m1_addr_i  : m0_addr_i;
                    wdata_d = grant ? m1_wdata_i : m0_wdata_i;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (we_q) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 3'd0) begin
                    if (owner_q) begin
                        rdata1_d = mem_rdata_i;
                    end else begin
                        rdata0_d = mem_rdata_i;
                    end
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state so reset clears strobes and acks immediately.
    always_comb begin
        mem_en_o    = (state_q == ST_ISSUE);
        mem_we_o    = we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        m0_ack_o    = (state_q == ST_ACK) && !owner_q;
        m1_ack_o    = (state_q == ST_ACK) && owner_q;
        m0_rdata_o  = rdata0_q;
        m1_rdata_o  = rdata1_q;
        busy_o      = (state_q != ST_IDLE);
        owner_o     = owner_q;
        dbg_state_o = state_q;
    end

endmodule

// File: tb/tb_module_mem_arbiter.sv
// Directed bench for module_mem_arbiter: one instance with MEM_LATENCY=1
// and one with MEM_LATENCY=3. The bench plays the memory by driving
// mem_rdata_i cycle by cycle. Cycle 0 is the IDLE cycle in which req is first sampled.
module tb_module_mem_arbiter;

    logic        clk;
    logic        rst_n;

    // MEM_LATENCY=1 instance signals
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m1_ack;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy, owner;
    logic [1:0]  dbg_state;

    // MEM_LATENCY=3 instance signals
    logic        b_m0_req, b_m0_we, b_m1_req, b_m1_we;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m1_addr, b_m1_wdata;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_m0_ack, b_m1_ack;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_busy, b_owner;
    logic [1:0]  b_dbg_state;

    int total;
    int bad;
    int acks0;
    int acks1;
    int en_pulses;

    module_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_rdata_o(m0_rdata), .m0_ack_o(m0_ack),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_rdata_o(m1_rdata), .m1_ack_o(m1_ack),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .busy_o(busy), .owner_o(owner), .dbg_state_o(dbg_state)
    );

    module_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst_n),
        .m0_req_i(b_m0_req), .m0_we_i(b_m0_we), .m0_addr_i(b_m0_addr), .m0_wdata_i(b_m0_wdata),
        .m0_rdata_o(b_m0_rdata), .m0_ack_o(b_m0_ack),
        .m1_req_i(b_m1_req), .m1_we_i(b_m1_we), .m1_addr_i(b_m1_addr), .m1_wdata_i(b_m1_wdata),
        .m1_rdata_o(b_m1_rdata), .m1_ack_o(b_m1_ack),
        .mem_en_o(b_mem_en), .mem_we_o(b_mem_we), .mem_addr_o(b_mem_addr),
        .mem_wdata_o(b_mem_wdata), .mem_rdata_i(b_mem_rdata),
        .busy_o(b_busy), .owner_o(b_owner), .dbg_state_o(b_dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0; bad = 0; acks0 = 0; acks1 = 0; en_pulses = 0;
        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        mem_rdata = 32'h0;
        b_m0_req = 0; b_m0_we = 0; b_m0_addr = 0; b_m0_wdata = 0;
        b_m1_req = 0; b_m1_we = 0; b_m1_addr = 0; b_m1_wdata = 0;
        b_mem_rdata = 32'h0;

        // Reset values
        #3;
        chk("rst_en", mem_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_mem", {mem_we, mem_addr, mem_wdata}, 0);
        chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
        chk("rst_owner", owner, 0);
        chk("rst_b_en", b_mem_en, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Master 0 read, latency 1
        m0_req = 1; m0_we = 0; m0_addr = 32'h10; mem_rdata = 32'h1111_1111;
        chk("rd_c0_en", mem_en, 0);
        tick();
        chk("rd_c1_en", mem_en, 1);
        chk("rd_c1_addr", mem_addr, 32'h10);
        chk("rd_c1_we", mem_we, 0);
        chk("rd_c1_owner", {busy, owner}, 2'b10);
        tick();
        chk("rd_c2_en", mem_en, 0);
        chk("rd_c2_ack", {m0_ack, m1_ack}, 0);
        mem_rdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_c3_ack", {m0_ack, m1_ack}, 2'b10);
        chk("rd_c3_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd_c3_en", mem_en, 0);
        mem_rdata = 32'h2222_2222;
        m0_req = 0;
        tick();
        chk("rd_c4_idle", {busy, m0_ack, m1_ack}, 0);
        chk("rd_c4_hold", m0_rdata, 32'hDEAD_BEEF);

        // Master 1 write, with inputs changed and req dropped after grant
        rst_n = 1'b0;
        #1;
        chk("rst_rdata_clr", m0_rdata, 0);
        do_reset();
        m1_req = 1; m1_we = 1; m1_addr = 32'h2000; m1_wdata = 32'hA5;
        tick();
        chk("wr_c1_en", {mem_en, mem_we}, 2'b11);
        chk("wr_c1_wdata", mem_wdata, 32'hA5);
        chk("wr_c1_addr", mem_addr, 32'h2000);
        chk("wr_c1_owner", {busy, owner}, 2'b11);
        m1_addr = 32'hFFFF; m1_wdata = 32'h5A; m1_req = 0;
        tick();
        chk("wr_c2_ack", {m0_ack, m1_ack}, 2'b01);
        chk("wr_c2_owner", {busy, owner, mem_en}, 3'b110);
        chk("wr_c2_addr_hold", {mem_addr, mem_wdata}, {32'h2000, 32'hA5});
        tick();
        chk("wr_c3_idle", {busy, m1_ack}, 0);
        tick();
        chk("wr_c4_idle", {busy, mem_en}, 0);

        // Simultaneous writes right after reset release
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h100; m0_wdata = 32'h1;
        m1_req = 1; m1_we = 1; m1_addr = 32'h200; m1_wdata = 32'h2;
        tick();
        chk("tie_c1_owner", {mem_en, owner}, 2'b10);
        chk("tie_c1_addr", mem_addr, 32'h100);
        tick();
        chk("tie_c2_ack", {m0_ack, m1_ack}, 2'b10);
        m0_req = 0;
        tick();
        chk("tie_c3_gap", {busy, mem_en}, 0);
        tick();
        chk("tie_c4_owner", {mem_en, owner}, 2'b11);
        chk("tie_c4_data", {mem_addr, mem_wdata}, {32'h200, 32'h2});
        tick();
        chk("tie_c5_ack", {m0_ack, m1_ack}, 2'b01);
        m1_req = 0;
        tick();
        chk("tie_c6_idle", busy, 0);

        // Continuous contention: 4 writes per master, strict alternation
        do_reset();
        m0_req = 1; m0_we = 1; m0_addr = 32'h400; m0_wdata = 32'h40;
        m1_req = 1; m1_we = 1; m1_addr = 32'h800; m1_wdata = 32'h80;
        for (int k = 0; k < 8; k++) begin
            chk("alt_idle", busy, 0);
            tick();
            chk("alt_owner", {mem_en, owner}, {1'b1, 1'(k % 2)});
            tick();
            chk("alt_ack", {m0_ack, m1_ack}, (k % 2 == 0) ? 2'b10 : 2'b01);
            if (m0_ack) acks0++;
            if (m1_ack) acks1++;
            if (acks0 == 4) m0_req = 0;
            if (acks1 == 4) m1_req = 0;
            tick();
        end
        chk("alt_cnt0", acks0, 4);
        chk("alt_cnt1", acks1, 4);
        chk("alt_end", busy, 0);

        // Latency 3 read on the second instance
        b_m0_req = 1; b_m0_we = 0; b_m0_addr = 32'h40; b_mem_rdata = 32'h3333_3333;
        tick();
        if (b_mem_en) en_pulses++;
        chk("l3_c1_en", {b_mem_en, b_mem_we, b_mem_addr}, {2'b10, 32'h40});
        tick();
        if (b_mem_en) en_pulses++;
        chk("l3_c2", {b_mem_en, b_m0_ack}, 0);
        tick();
        if (b_mem_en) en_pulses++;
        chk("l3_c3", {b_mem_en, b_m0_ack, b_dbg_state}, {2'b00, 2'd2});
        tick();
        if (b_mem_en) en_pulses++;
        chk("l3_c4", {b_mem_en, b_m0_ack}, 0);
        b_mem_rdata = 32'h1234_5678;
        tick();
        if (b_mem_en) en_pulses++;
        chk("l3_c5_ack", {b_m0_ack, b_m1_ack}, 2'b10);
        chk("l3_c5_rdata", b_m0_rdata, 32'h1234_5678);
        b_mem_rdata = 32'h4444_4444;
        b_m0_req = 0;
        tick();
        if (b_mem_en) en_pulses++;
        chk("l3_en_pulses", en_pulses, 1);
        chk("l3_c6_idle", {b_busy, b_m0_ack}, 0);

        // Reset during WAIT of a master 1 read
        do_reset();
        m0_we = 0; m1_we = 0;
        m1_req = 1; m1_addr = 32'h300; mem_rdata = 32'h5555_5555;
        tick();
        chk("ra_c1", {mem_en, owner}, 2'b11);
        tick();
        chk("ra_c2_wait", dbg_state, 2'd2);
        rst_n = 1'b0;
        m1_req = 0;
        #1;
        chk("ra_outs", {busy, mem_en, mem_we, m0_ack, m1_ack, owner}, 0);
        chk("ra_mem", {mem_addr, mem_wdata}, 0);
        chk("ra_rdata", {m0_rdata, m1_rdata}, 0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ra_no_ack", {busy, m0_ack, m1_ack}, 0);
        end
        m0_req = 1; m0_addr = 32'h500;
        m1_req = 1; m1_addr = 32'h600;
        tick();
        chk("ra_tie_owner", {mem_en, owner}, 2'b10);
        chk("ra_tie_addr", mem_addr, 32'h500);
        mem_rdata = 32'h6666_6666;
        tick();
        tick();
        chk("ra_tie_ack", {m0_ack, m1_ack}, 2'b10);
        chk("ra_tie_rdata", m0_rdata, 32'h6666_6666);
        m0_req = 0; m1_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
